// File: rtl/calc_pkg.sv
// Shared types and result-packing helpers for the sequential calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Quotient occupies the low half of result, remainder the high half.
  localparam int QUO_LSB = 0;

  function automatic int rem_lsb(input int w);
    return w;
  endfunction

  function automatic int carry_bit(input int w);
    return w;
  endfunction

endpackage

// File: rtl/seq_calc_step.sv
// One combinational iteration of shift-add multiply (mode=0) or restoring divide (mode=1).
module seq_calc_step #(
  parameter int W = 4
) (
  input  logic           mode,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] next_acc
);

  logic [W:0]   sum;
  logic [W:0]   tmp;
  logic [W-1:0] diff;

  always_comb begin
    sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    tmp  = acc[2*W-1:W-1];
    // Only used when tmp >= opnd, where the difference is below opnd and fits in W bits.
    diff = tmp[W-1:0] - opnd;
    if (mode) begin
      if (tmp >= {1'b0, opnd}) next_acc = {diff, acc[W-2:0], 1'b1};
      else                     next_acc = {tmp[W-1:0], acc[W-2:0], 1'b0};
    end else if (acc[0]) begin
      next_acc = {sum, acc[W-1:1]};
    end else begin
      next_acc = {1'b0, acc[2*W-1:1]};
    end
  end

endmodule

// File: rtl/seq_calc.sv
// Clocked ADD/SUB/MUL/DIV calculator with valid/ready on both sides and a shared iterative datapath.
module seq_calc
  import calc_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           flag,
  output logic [1:0]     dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and result/flag hold until taken.

  localparam int REM_LSB   = rem_lsb(W);
  localparam int CARRY_BIT = carry_bit(W);

  state_e         state;
  logic [CW-1:0]  cnt;
  op_e            op_r;
  logic [W-1:0]   opnd_r;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] next_acc;
  logic [W:0]     add_sum;
  logic [W-1:0]   sub_diff;
  op_e            op_in;

  always_comb begin
    op_in    = op_e'(op);
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = a - b;
  end

  seq_calc_step #(.W(W)) u_step (
    .mode     (op_r == OP_DIV),
    .acc      (acc),
    .opnd     (opnd_r),
    .next_acc (next_acc)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= 1'b0;
      cnt       <= '0;
      op_r      <= OP_ADD;
      opnd_r    <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r     <= op_in;
            opnd_r   <= b;
            acc      <= {{W{1'b0}}, a};
            in_ready <= 1'b0;
            case (op_in)
              OP_ADD: begin
                result    <= {{(W-1){1'b0}}, add_sum};
                flag      <= add_sum[CARRY_BIT];
                state     <= S_DONE;
                out_valid <= 1'b1;
              end
              OP_SUB: begin
                result    <= {{W{1'b0}}, sub_diff};
                flag      <= (a < b);
                state     <= S_DONE;
                out_valid <= 1'b1;
              end
              default: begin
                if (op_in == OP_DIV && b == '0) begin
                  result                 <= '0;
                  result[QUO_LSB +: W]   <= '1;
                  result[REM_LSB +: W]   <= a;
                  flag                   <= 1'b1;
                  state                  <= S_DONE;
                  out_valid              <= 1'b1;
                end else begin
                  cnt   <= CW'(W);
                  state <= S_BUSY;
                end
              end
            endcase
          end
        end
        S_BUSY: begin
          acc <= next_acc;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= next_acc;
            flag      <= 1'b0;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calc.sv
// Directed scoreboard bench for seq_calc at W=4 plus a W=8 instance for wide multiply/divide.
module tb_seq_calc;

  localparam int W  = 4;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- W=4 instance ----------------
  logic           in_valid, in_ready, out_valid, out_ready, flag;
  logic [1:0]     op, dbg_state;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] result;

  seq_calc #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .dbg_state(dbg_state)
  );

  // ---------------- W=8 instance ----------------
  logic            in_valid8, in_ready8, out_valid8, out_ready8, flag8;
  logic [1:0]      op8, dbg_state8;
  logic [W8-1:0]   a8, b8;
  logic [2*W8-1:0] result8;

  seq_calc #(.W(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag(flag8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [2*W:0]  exp_q[$];
  int            lat_q[$];
  logic [2*W8:0] exp8_q[$];
  int            lat8_q[$];

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] er, input logic ef, input int lat, input bit push);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      exp_q.push_back({ef, er});
      lat_q.push_back(cyc + lat - 1);
    end
  endtask

  task automatic issue8(input logic [1:0] o, input logic [W8-1:0] x, input logic [W8-1:0] y,
                        input logic [2*W8-1:0] er, input logic ef, input int lat);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
    while (!in_ready8 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready8) begin
      check("accept8_timeout", in_ready8, 1);
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    exp8_q.push_back({ef, er});
    lat8_q.push_back(cyc + lat - 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_wait", exp_q.size(), 0);
  endtask

  // ---------------- monitors ----------------
  logic          was_valid = 1'b0;
  logic [2*W:0]  held, e4;
  int            first_cyc, l4;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_valid = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!was_valid) first_cyc = cyc;
        else check("hold_stable", {flag, result}, held);
        held = {flag, result};
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_output: got 0x%0h with no pending command", {flag, result});
          end else begin
            e4 = exp_q.pop_front();
            l4 = lat_q.pop_front();
            check("flag_result", {flag, result}, e4);
            check("latency_cycle", first_cyc, l4);
          end
          was_valid = 1'b0;
        end else begin
          was_valid = 1'b1;
        end
      end else begin
        was_valid = 1'b0;
      end
    end
  end

  logic          was_valid8 = 1'b0;
  logic [2*W8:0] e8;
  int            first_cyc8, l8;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_valid8 = 1'b0;
        continue;
      end
      if (out_valid8 && !was_valid8) first_cyc8 = cyc;
      was_valid8 = out_valid8 && !out_ready8;
      if (out_valid8 && out_ready8) begin
        if (exp8_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_output8: got 0x%0h with no pending command", {flag8, result8});
        end else begin
          e8 = exp8_q.pop_front();
          l8 = lat8_q.pop_front();
          check("flag_result8", {flag8, result8}, e8);
          check("latency_cycle8", first_cyc8, l8);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flag", flag, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    issue(ADD, 4'd9,  4'd8,  8'h11, 1'b1, 1, 1'b1);
    issue(SUB, 4'd3,  4'd5,  8'h0E, 1'b1, 1, 1'b1);
    issue(SUB, 4'd7,  4'd7,  8'h00, 1'b0, 1, 1'b1);
    issue(ADD, 4'd15, 4'd15, 8'h1E, 1'b1, 1, 1'b1);
    issue(MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 5, 1'b1);
    for (int i = 0; i < W; i++) begin
      check("busy_in_ready", in_ready, 0);
      check("busy_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    issue(DIV, 4'd13, 4'd4,  8'h13, 1'b0, 5, 1'b1);
    issue(DIV, 4'd9,  4'd0,  8'h9F, 1'b1, 1, 1'b1);
    issue(MUL, 4'd0,  4'd9,  8'h00, 1'b0, 5, 1'b1);
    issue(DIV, 4'd3,  4'd7,  8'h30, 1'b0, 5, 1'b1);

    // Backpressure: result must hold and no new command may slip in.
    wait_idle();
    out_ready = 1'b0;
    issue(MUL, 4'd6, 4'd7, 8'h2A, 1'b0, 5, 1'b1);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; op = ADD; a = 4'd1; b = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 8'h2A);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a divide.
    wait_idle();
    issue(DIV, 4'd15, 4'd2, 8'h17, 1'b0, 5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_flag", flag, 0);
    check("abort_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(DIV, 4'd15, 4'd2, 8'h17, 1'b0, 5, 1'b1);

    // Wider instance.
    issue8(MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 9);
    issue8(DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 9);
    issue8(ADD, 8'd255, 8'd1,   16'h0100, 1'b1, 1);

    for (int i = 0; i < 200 && (exp_q.size() != 0 || exp8_q.size() != 0); i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("drain", exp_q.size(), 0);
    check("drain8", exp8_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
